mem_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the shared 4 KB byte-addressed, big-endian 16-bit-word memory. It lets the MCU core (port 0) and a loader/DMA requester (port 1) share the single memory port. It serialises their word accesses, generates the memory write strobe, and returns registered read data with a one-cycle acknowledge. It sits between the requesters and `memory`; the top level tri-states the memory `data` bus from `mem_wdata` when `mem_w` is high.

---
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the shared 4 KB big-endian word memory: IDLE -> ACC -> DONE, ack in DONE.
// Build option MEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking; otherwise port 0 has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_w,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t            state;
  logic              we_q;
  logic              win;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_bad;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Separate from owner so that port 0 takes the first tie after reset.
  logic rr_last;
  always_comb win = (req0 & req1) ? ~rr_last : req1;
`else
  always_comb win = ~req0;
`endif

  always_comb begin
    w_we    = win ? we1    : we0;
    w_addr  = win ? addr1  : addr0;
    w_wdata = win ? wdata1 : wdata0;
    // The last byte cannot hold a whole word.
    w_bad   = (w_addr == {ADDR_W{1'b1}});
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      mem_w     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      owner     <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_last   <= 1'b1;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            owner     <= win;
            we_q      <= w_we;
            mem_addr  <= w_addr;
            mem_wdata <= w_wdata;
            busy      <= 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_last   <= win;
`endif
            if (w_bad) begin
              state <= DONE;
              if (win) begin
                ack1 <= 1'b1;
                err1 <= 1'b1;
                if (!w_we) rdata1 <= '0;
              end else begin
                ack0 <= 1'b1;
                err0 <= 1'b1;
                if (!w_we) rdata0 <= '0;
              end
            end else begin
              state <= ACC;
              mem_w <= w_we;
            end
          end
        end
        ACC: begin
          state <= DONE;
          mem_w <= 1'b0;
          if (owner) begin
            ack1 <= 1'b1;
            if (!we_q) rdata1 <= mem_rdata;
          end else begin
            ack0 <= 1'b1;
            if (!we_q) rdata0 <= mem_rdata;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          mem_w <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter with a byte-array memory and a word-level reference model.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [11:0] addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, err0, err1, mem_w, busy, owner;
  logic [15:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [11:0] mem_addr;

  int compared = 0;
  int mismatched = 0;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic [7:0] mem     [0:4095];
  logic [7:0] ref_mem [0:4095];

  int          memw_cnt = 0, ack0_cnt = 0, ack1_cnt = 0;
  logic [11:0] last_w_addr = '0;
  logic [15:0] last_w_data = '0;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_w(mem_w), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  always #5 clock = ~clock;

  // Environment memory: big-endian word, high byte at the lower address.
  assign mem_rdata = {mem[mem_addr], mem[mem_addr + 12'd1]};
  always @(posedge clock) begin
    if (mem_w) begin
      mem[mem_addr]         <= mem_wdata[15:8];
      mem[mem_addr + 12'd1] <= mem_wdata[7:0];
    end
  end

  always @(negedge clock) begin
    if (mem_w) begin
      memw_cnt    <= memw_cnt + 1;
      last_w_addr <= mem_addr;
      last_w_data <= mem_wdata;
    end
    if (ack0) ack0_cnt <= ack0_cnt + 1;
    if (ack1) ack1_cnt <= ack1_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_word(input logic [11:0] a);
    return {ref_mem[a], ref_mem[a + 12'd1]};
  endfunction

  // One isolated access on one port, starting and ending at a falling edge with the arbiter idle.
  task automatic run_access(input logic p, input logic we, input logic [11:0] a, input logic [15:0] d);
    int          lat, w0, a0, a1;
    logic        bad, ackv;
    logic [15:0] exp_rd;
    bad    = (a == 12'hFFF);
    exp_rd = bad ? 16'h0 : ref_word(a);
    w0 = memw_cnt; a0 = ack0_cnt; a1 = ack1_cnt;
    if (p) begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
    else   begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
    lat = 0;
    do begin
      @(posedge clock); lat++; @(negedge clock);
      ackv = p ? ack1 : ack0;
    end while (!ackv && lat < 10);
    check("ack_latency", 64'(lat), bad ? 64'd1 : 64'd2);
    check("err", 64'(p ? err1 : err0), 64'(bad));
    check("owner", 64'(owner), 64'(p));
    if (!we) check("rdata", 64'(p ? rdata1 : rdata0), 64'(exp_rd));
    req0 = 0; req1 = 0;
    @(negedge clock);
    check("mem_w_pulses", 64'(memw_cnt - w0), (we && !bad) ? 64'd1 : 64'd0);
    check("own_ack_count", 64'(p ? ack1_cnt - a1 : ack0_cnt - a0), 64'd1);
    check("other_ack_count", 64'(p ? ack0_cnt - a0 : ack1_cnt - a1), 64'd0);
    if (we && !bad) begin
      check("write_addr", 64'(last_w_addr), 64'(a));
      check("write_data", 64'(last_w_data), 64'(d));
      ref_mem[a]         = d[15:8];
      ref_mem[a + 12'd1] = d[7:0];
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctl"}, {58'd0, ack0, ack1, err0, err1, mem_w, busy, owner} , 64'd0);
    check({tag, "_data"}, {rdata0, rdata1, mem_wdata, 4'd0, mem_addr}, 64'd0);
  endtask

  initial begin
    int          diffs, lat, a0, a1, p;
    logic [11:0] a;
    logic [7:0]  b;
    for (int i = 0; i < 4096; i++) begin
      b = 8'($urandom);
      mem[i] = b; ref_mem[i] = b;
    end
    mem[12'h010] = 8'h12; mem[12'h011] = 8'h34;
    ref_mem[12'h010] = 8'h12; ref_mem[12'h011] = 8'h34;

    repeat (2) @(negedge clock);
    check_outputs_zero("reset_state");
    reset = 1;
    @(negedge clock);

    // Read on port 0 of a known word.
    run_access(1'b0, 1'b0, 12'h010, 16'h0);
    check("read_0x010", 64'(rdata0), 64'h1234);

    // Write then read back on port 1.
    run_access(1'b1, 1'b1, 12'h020, 16'hBEEF);
    check("mem_byte_0x20", 64'(mem[12'h020]), 64'hBE);
    check("mem_byte_0x21", 64'(mem[12'h021]), 64'hEF);
    run_access(1'b1, 1'b0, 12'h020, 16'h0);
    check("readback_0x020", 64'(rdata1), 64'hBEEF);

    // Rejected end-of-memory accesses.
    run_access(1'b0, 1'b1, 12'hFFF, 16'h5A5A);
    check("mem_fff_untouched", 64'(mem[12'hFFF]), 64'(ref_mem[12'hFFF]));
    run_access(1'b1, 1'b0, 12'hFFF, 16'h0);
    check("rejected_read_rdata", 64'(rdata1), 64'h0);
    run_access(1'b0, 1'b0, 12'hFFE, 16'h0);
    run_access(1'b1, 1'b1, 12'h033, 16'hC0DE);
    run_access(1'b0, 1'b0, 12'h033, 16'h0);

    // Random single-port traffic.
    for (int i = 0; i < 80; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom_range(0, 4095));
      run_access(1'($urandom), 1'($urandom), a, 16'($urandom));
    end
    diffs = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check("memory_image_diffs", 64'(diffs), 64'd0);

    // Reset in the middle of a write aborts it.
    a0 = ack0_cnt;
    req0 = 1; we0 = 1; addr0 = 12'h040; wdata0 = 16'hA5A5;
    @(posedge clock); @(negedge clock);
    check("abort_mem_w_in_acc", 64'(mem_w), 64'd1);
    check("abort_addr_in_acc", 64'(mem_addr), 64'h040);
    #2 reset = 0;
    #1 check("abort_mem_w_async", 64'(mem_w), 64'd0);
    check_outputs_zero("abort_outputs");
    @(negedge clock); req0 = 0; we0 = 0;
    @(negedge clock); reset = 1;
    @(negedge clock); @(negedge clock);
    check("abort_no_ack", 64'(ack0_cnt - a0), 64'd0);
    check("abort_idle", 64'(busy), 64'd0);
    check("abort_mem_unchanged", {48'd0, mem[12'h040], mem[12'h041]}, 64'(ref_word(12'h040)));
    run_access(1'b0, 1'b0, 12'h040, 16'h0);

    // Both ports held requesting across four grants, fresh out of reset.
    reset = 0;
    @(negedge clock); reset = 1;
    @(negedge clock);
    a1 = ack1_cnt;
    req0 = 1; we0 = 0; addr0 = 12'h100;
    req1 = 1; we1 = 0; addr1 = 12'h202;
    for (int g = 0; g < 4; g++) begin
      lat = 0;
      do begin @(posedge clock); lat++; @(negedge clock); end while (!(ack0 || ack1) && lat < 10);
      check("tie_gap", 64'(lat), (g == 0) ? 64'd2 : 64'd3);
      p = RR ? (g % 2) : 0;
      check("tie_winner", {62'd0, ack1, ack0}, (p == 1) ? 64'd2 : 64'd1);
      check("tie_rdata", 64'(p ? rdata1 : rdata0), 64'(ref_word(p ? 12'h202 : 12'h100)));
    end
    req0 = 0; req1 = 0;
    @(negedge clock); @(negedge clock);
    check("tie_port1_grants", 64'(ack1_cnt - a1), RR ? 64'd2 : 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
